// File: rtl/mips32_mem_dump_if.sv
// Memory read port and output stream bundle for the MIPS32 data-memory dump engine.
// The master side is the dump engine; the slave side is the memory plus stream consumer.
interface mips32_mem_dump_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output mem_rd_en, mem_addr, out_valid, out_addr, out_data, out_last,
    input  mem_rd_data, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, out_valid, out_addr, out_data, out_last,
    output mem_rd_data, out_ready
  );
endinterface

// File: rtl/mips32_mem_dump.sv
// Readback engine: streams a window of MIPS32 data-memory words on a valid/ready port.
// Optional MIPS32_DUMP_CHECKSUM_EN appends a modular-sum word after the data words.
module mips32_mem_dump #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic              halted,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  mips32_mem_dump_if.master dif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_CSUM,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cur;
  logic [LEN_W-1:0]  remaining;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic              rd_en_c;
  logic              out_valid_c;
  logic              busy_c;
  logic              done_c;
  logic              hs;
  logic              last_word;
`ifdef MIPS32_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc;
`endif

  // Auto-dump on CPU halt is not part of this build; keep the input tied off.
  logic halted_unused;
  assign halted_unused = halted;

  assign hs        = out_valid_c && dif.out_ready;
  assign last_word = (remaining <= LEN_W'(1));

  always_ff @(posedge clk1) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rd_en_c     = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = (state != S_IDLE);
    done_c      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_nxt = S_REQ;
          end else begin
`ifdef MIPS32_DUMP_CHECKSUM_EN
            state_nxt = S_CSUM;
`else
            state_nxt = S_DONE;
`endif
          end
        end
      end
      S_REQ: begin
        rd_en_c   = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid_c = 1'b1;
        if (dif.out_ready) begin
          if (!last_word) begin
            state_nxt = S_REQ;
          end else begin
`ifdef MIPS32_DUMP_CHECKSUM_EN
            state_nxt = S_CSUM;
`else
            state_nxt = S_DONE;
`endif
          end
        end
      end
      S_CSUM: begin
        out_valid_c = 1'b1;
        if (dif.out_ready) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_c    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      cur        <= '0;
      remaining  <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
`ifdef MIPS32_DUMP_CHECKSUM_EN
      acc        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur       <= base_addr;
            remaining <= len;
`ifdef MIPS32_DUMP_CHECKSUM_EN
            acc       <= '0;
            if (len == '0) begin
              out_data_q <= '0;
              out_addr_q <= base_addr;
              out_last_q <= 1'b1;
            end
`endif
          end
        end
        // Read data arrives one cycle after the REQ strobe; register it for the stream.
        S_WAIT: begin
          out_data_q <= dif.mem_rd_data;
          out_addr_q <= cur;
`ifdef MIPS32_DUMP_CHECKSUM_EN
          out_last_q <= 1'b0;
          acc        <= acc + dif.mem_rd_data;
`else
          out_last_q <= (remaining == LEN_W'(1));
`endif
        end
        S_OUT: begin
          if (hs) begin
            cur       <= cur + 1'b1;
            remaining <= remaining - 1'b1;
`ifdef MIPS32_DUMP_CHECKSUM_EN
            if (last_word) begin
              out_data_q <= acc;
              out_addr_q <= cur + 1'b1;
              out_last_q <= 1'b1;
            end
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy          = busy_c;
  assign done          = done_c;
  assign dif.mem_rd_en = rd_en_c;
  assign dif.mem_addr  = cur;
  assign dif.out_valid = out_valid_c;
  assign dif.out_addr  = out_addr_q;
  assign dif.out_data  = out_data_q;
  assign dif.out_last  = out_last_q;

endmodule

// File: tb/tb_mips32_mem_dump.sv
// Randomized self-checking bench for mips32_mem_dump against a queue-based reference of
// the expected word stream, with a synchronous 1-cycle-latency memory model.
module tb_mips32_mem_dump;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LW = 11;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } word_t;

  logic          clk1 = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          halted = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy;
  logic          done;

  mips32_mem_dump_if #(.ADDR_W(AW), .DATA_W(DW)) dif ();

  mips32_mem_dump #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk1      (clk1),
    .rst       (rst),
    .start     (start),
    .halted    (halted),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .dif       (dif)
  );

  always #5 clk1 = ~clk1;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk1) begin
    if (dif.mem_rd_en) dif.mem_rd_data <= mem[dif.mem_addr];
  end

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  word_t exp_q[$];
  word_t got_q[$];
  bit    mon_en = 1'b0;
  int    rd_cnt, done_cnt, hs_cnt, first_valid_cyc, last_hs_cyc, done_cyc;
  bit    prev_stall = 1'b0;
  word_t held;

  always @(negedge clk1) begin
    word_t e, g;
    if (mon_en) begin
      if (dif.mem_rd_en) rd_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (dif.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) begin
        chk("hold_valid", dif.out_valid, 1);
        chk("hold_word", {dif.out_addr, dif.out_data, dif.out_last}, held);
      end
      prev_stall = dif.out_valid && !dif.out_ready;
      held = '{a: dif.out_addr, d: dif.out_data, l: dif.out_last};
      if (dif.out_valid && dif.out_ready) begin
        g = '{a: dif.out_addr, d: dif.out_data, l: dif.out_last};
        got_q.push_back(g);
        if (exp_q.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("word_addr", g.a, e.a);
          chk("word_data", g.d, e.d);
          chk("word_last", g.l, e.l);
        end
        hs_cnt++;
        last_hs_cyc = cyc;
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rden"}, dif.mem_rd_en, 0);
    chk({tag, "_maddr"}, dif.mem_addr, 0);
    chk({tag, "_valid"}, dif.out_valid, 0);
    chk({tag, "_oaddr"}, dif.out_addr, 0);
    chk({tag, "_odata"}, dif.out_data, 0);
    chk({tag, "_olast"}, dif.out_last, 0);
  endtask

  task automatic build_expect(input logic [AW-1:0] b, input logic [LW-1:0] n);
    logic [AW-1:0] a;
    logic [DW-1:0] sum;
    exp_q.delete();
    got_q.delete();
    sum = '0;
    for (int i = 0; i < int'(n); i++) begin
      a = b + AW'(i);
`ifdef MIPS32_DUMP_CHECKSUM_EN
      exp_q.push_back('{a: a, d: mem[a], l: 1'b0});
`else
      exp_q.push_back('{a: a, d: mem[a], l: (i == int'(n) - 1)});
`endif
      sum = sum + mem[a];
    end
`ifdef MIPS32_DUMP_CHECKSUM_EN
    exp_q.push_back('{a: b + n[AW-1:0], d: sum, l: 1'b1});
`endif
    rd_cnt = 0; done_cnt = 0; hs_cnt = 0;
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    prev_stall = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: hold ready low 5 cycles per presented word
  task automatic run_dump(input string tag, input logic [AW-1:0] b, input logic [LW-1:0] n,
                          input int mode, input int restart_at);
    int s_cyc, k, stall, budget, nw;
    build_expect(b, n);
    mon_en = 1'b1;
    budget = int'(n) * 12 + 40;
    stall = 0;
    k = 0;
    s_cyc = cyc;
    while (done_cnt == 0 && k < budget) begin
      if (k == 0) begin
        start = 1'b1; base_addr = b; len = n; s_cyc = cyc;
      end else if (k == restart_at) begin
        start = 1'b1; base_addr = AW'($urandom); len = 11'd7;
      end else begin
        start = 1'b0; base_addr = AW'($urandom); len = LW'($urandom);
      end
      case (mode)
        0: dif.out_ready = 1'b1;
        1: dif.out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (dif.out_valid && stall < 5) begin
            dif.out_ready = 1'b0;
            stall++;
          end else begin
            dif.out_ready = 1'b1;
            if (dif.out_valid) stall = 0;
          end
        end
      endcase
      @(posedge clk1); #1;
      k++;
    end
    start = 1'b0;
    dif.out_ready = 1'b1;
    if (done_cnt == 0) chk({tag, "_done_timeout"}, 0, 1);
    repeat (3) begin
      @(posedge clk1); #1;
    end
    nw = int'(n);
`ifdef MIPS32_DUMP_CHECKSUM_EN
    nw = nw + 1;
`endif
    chk({tag, "_words"}, hs_cnt, nw);
    chk({tag, "_leftover"}, exp_q.size(), 0);
    chk({tag, "_reads"}, rd_cnt, int'(n));
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_busy_end"}, busy, 0);
    if (nw == 0) begin
      chk({tag, "_done_lat"}, done_cyc, s_cyc + 1);
      chk({tag, "_no_valid"}, first_valid_cyc, -1);
    end else begin
      chk({tag, "_done_lat"}, done_cyc, last_hs_cyc + 1);
      chk({tag, "_first_valid"}, first_valid_cyc, (n == 0) ? s_cyc + 1 : s_cyc + 3);
    end
    mon_en = 1'b0;
  endtask

  initial begin
    int w;
    bit seen;
    logic [AW-1:0] rb;
    logic [LW-1:0] rl;

    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    mem[198] = 32'd5040;
    mem[199] = 32'd0;
    mem[200] = 32'd7;
    dif.out_ready = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk1);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // Factorial readback with the consumer always ready
    run_dump("fact", 10'd198, 11'd3, 0, -1);
    chk("fact_n", got_q.size() >= 3, 1);
    if (got_q.size() >= 3) begin
      chk("fact_w0", {got_q[0].a, got_q[0].d, got_q[0].l}, {10'd198, 32'd5040, 1'b0});
      chk("fact_w1", {got_q[1].a, got_q[1].d, got_q[1].l}, {10'd199, 32'd0, 1'b0});
`ifdef MIPS32_DUMP_CHECKSUM_EN
      chk("fact_w2", {got_q[2].a, got_q[2].d, got_q[2].l}, {10'd200, 32'd7, 1'b0});
      if (got_q.size() >= 4)
        chk("fact_csum", {got_q[3].a, got_q[3].d, got_q[3].l}, {10'd201, 32'd5047, 1'b1});
      else
        chk("fact_csum_missing", got_q.size(), 4);
`else
      chk("fact_w2", {got_q[2].a, got_q[2].d, got_q[2].l}, {10'd200, 32'd7, 1'b1});
`endif
    end

    run_dump("bp", 10'd198, 11'd3, 2, -1);
    run_dump("zero", 10'd55, 11'd0, 0, -1);

    run_dump("wrap", 10'd1022, 11'd4, 1, -1);
    if (got_q.size() >= 4) begin
      chk("wrap_a0", got_q[0].a, 10'd1022);
      chk("wrap_a1", got_q[1].a, 10'd1023);
      chk("wrap_a2", got_q[2].a, 10'd0);
      chk("wrap_a3", got_q[3].a, 10'd1);
    end else begin
      chk("wrap_count", got_q.size(), 4);
    end

    run_dump("restart", 10'd300, 11'd5, 0, 4);

    // Reset during the second word's output phase
    build_expect(10'd400, 11'd5);
    mon_en = 1'b1;
    start = 1'b1; base_addr = 10'd400; len = 11'd5; dif.out_ready = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
    w = 0;
    while (hs_cnt < 1 && w < 20) begin
      @(posedge clk1); #1; w++;
    end
    dif.out_ready = 1'b0;
    while (!dif.out_valid && w < 40) begin
      @(posedge clk1); #1; w++;
    end
    chk("rst_mid_reached", {dif.out_valid, dif.out_addr}, {1'b1, 10'd401});
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk1); #1;
    rst = 1'b0;
    chk_zero("rst_mid");
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk1);
      if (done || dif.out_valid || dif.mem_rd_en) seen = 1'b1;
    end
    chk("rst_mid_quiet", seen, 0);
    @(posedge clk1); #1;

    // start and rst together: reset wins
    start = 1'b1; rst = 1'b1; base_addr = 10'd10; len = 11'd3;
    @(posedge clk1); #1;
    start = 1'b0; rst = 1'b0;
    chk("rst_start_busy", busy, 0);
    @(posedge clk1); #1;
    chk("rst_start_idle", {busy, dif.mem_rd_en}, 2'b00);

    for (int t = 0; t < 8; t++) begin
      rb = AW'($urandom);
      rl = LW'($urandom_range(1, 12));
      run_dump("rand", rb, rl, 1, (t % 2 == 0) ? 2 : -1);
    end

    run_dump("big", 10'd900, 11'd1100, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
